// File: rtl/rotate_pkg.sv
// Shared constants and types for the rotating-square ring display driver.
package rotate_pkg;

  localparam logic [6:0] SEG_UPPER = 7'h1C;
  localparam logic [6:0] SEG_LOWER = 7'h23;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {ROTATE = 1'b0, BOUNCE = 1'b1} mode_t;

endpackage

// File: rtl/tick_gen.sv
// Enabled free-running W-bit counter; max_tick marks the enabled cycle on which it wraps.
module tick_gen #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic max_tick
);

  logic [W-1:0] cnt_q;

  assign max_tick = en && (cnt_q == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/rotate_square_ring.sv
// Moves an upper/lower square around a 2*DIGITS ring on a multiplexed seven-segment display,
// in rotate or bounce mode, with registered active-low anode and segment outputs.
module rotate_square_ring
  import rotate_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_W    = 25,
  parameter int unsigned REFRESH_W = 16,
  localparam int unsigned POS_W    = $clog2(2 * DIGITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up,
  input  logic              mode,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        sseg,
  output logic [POS_W-1:0]  pos,
  output logic              lap
);

  // $clog2(2*D) == $clog2(D) + 1, so scan needs one bit less than pos.
  localparam int unsigned SCAN_W = POS_W - 1;
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(2 * DIGITS - 1);
  localparam logic [POS_W-1:0]  POS_DIG   = POS_W'(DIGITS);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(DIGITS - 1);

  mode_t mode_e;
  logic  step, refresh;

  logic [POS_W-1:0]  pos_q, pos_d, pos_inc, pos_dec, sq_digit;
  logic              dir_q, dir_d, lap_q, lap_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        sseg_q, sseg_d, sq_pat;

  assign mode_e = mode_t'(mode);

  tick_gen #(.W(TICK_W)) u_step_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .max_tick (step)
  );

  tick_gen #(.W(REFRESH_W)) u_refresh_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (1'b1),
    .max_tick (refresh)
  );

  assign pos_inc = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
  assign pos_dec = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    lap_d = 1'b0;
    if (mode_e == ROTATE) begin
      dir_d = up;
      if (step) begin
        pos_d = up ? pos_inc : pos_dec;
        lap_d = up ? (pos_q == POS_LAST) : (pos_q == '0);
      end
    end else if (step) begin
      // At either end of the sweep: reverse and move straight away, no dwell.
      if (dir_q ? (pos_q == POS_LAST) : (pos_q == '0)) begin
        dir_d = ~dir_q;
        lap_d = 1'b1;
        pos_d = dir_q ? pos_dec : pos_inc;
      end else begin
        pos_d = dir_q ? pos_inc : pos_dec;
      end
    end
  end

  always_comb begin
    if (pos_q < POS_DIG) begin
      sq_digit = POS_DIG - POS_W'(1) - pos_q;
      sq_pat   = SEG_UPPER;
    end else begin
      sq_digit = pos_q - POS_DIG;
      sq_pat   = SEG_LOWER;
    end
    scan_d = scan_q;
    if (refresh) begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
    end
    an_d   = ~(DIGITS'(1) << scan_q);
    sseg_d = ({1'b0, scan_q} == sq_digit) ? sq_pat : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q  <= '0;
      dir_q  <= 1'b1;
      lap_q  <= 1'b0;
      scan_q <= '0;
      an_q   <= '1;
      sseg_q <= SEG_BLANK;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      lap_q  <= lap_d;
      scan_q <= scan_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign pos  = pos_q;
  assign lap  = lap_q;
  assign an   = an_q;
  assign sseg = sseg_q;

endmodule

// File: tb/tb_rotate_square_ring.sv
// Bench for rotate_square_ring: a 4-digit and a 3-digit instance share stimulus and are
// compared each cycle against an arithmetic ring model, plus directed literal checks.
module tb_rotate_square_ring;

  localparam int TW = 2;
  localparam int RW = 1;

  logic clk = 1'b0;
  logic rst, en, up, mode;

  logic [3:0] an0;
  logic [6:0] sseg0;
  logic [2:0] pos0;
  logic       lap0;
  logic [2:0] an1;
  logic [6:0] sseg1;
  logic [2:0] pos1;
  logic       lap1;

  rotate_square_ring #(.DIGITS(4), .TICK_W(TW), .REFRESH_W(RW)) u_dut4 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .mode (mode),
    .an   (an0),
    .sseg (sseg0),
    .pos  (pos0),
    .lap  (lap0)
  );

  rotate_square_ring #(.DIGITS(3), .TICK_W(TW), .REFRESH_W(RW)) u_dut3 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .mode (mode),
    .an   (an1),
    .sseg (sseg1),
    .pos  (pos1),
    .lap  (lap1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ring position, prescaler counts and scan slot as plain integers.
  int D[2] = '{4, 3};
  int mpos[2], mdir[2], mtcnt[2], mrcnt[2], mscan[2], man[2], msseg[2], mlap[2];
  bit mvalid = 1'b0;

  function automatic int digit_of(input int p, input int d);
    return (p < d) ? d - 1 - p : p - d;
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 2; k++) begin
      int n, dg;
      bit stp, rt;
      if (rst) begin
        mpos[k] = 0; mdir[k] = 1; mtcnt[k] = 0; mrcnt[k] = 0; mscan[k] = 0;
        man[k] = (1 << D[k]) - 1; msseg[k] = 'h7F; mlap[k] = 0;
      end else begin
        n   = 2 * D[k];
        stp = en && (mtcnt[k] == (1 << TW) - 1);
        if (en) mtcnt[k] = (mtcnt[k] + 1) % (1 << TW);
        rt = (mrcnt[k] == (1 << RW) - 1);
        mrcnt[k] = (mrcnt[k] + 1) % (1 << RW);
        dg = digit_of(mpos[k], D[k]);
        man[k] = ((1 << D[k]) - 1) & ~(1 << mscan[k]);
        msseg[k] = (dg == mscan[k]) ? ((mpos[k] < D[k]) ? 'h1C : 'h23) : 'h7F;
        if (rt) mscan[k] = (mscan[k] + 1) % D[k];
        mlap[k] = 0;
        if (stp) begin
          if (!mode) begin
            mlap[k] = up ? int'(mpos[k] == n - 1) : int'(mpos[k] == 0);
            mpos[k] = (mpos[k] + (up ? 1 : n - 1)) % n;
          end else begin
            if ((mdir[k] != 0) ? (mpos[k] == n - 1) : (mpos[k] == 0)) begin
              mdir[k] = (mdir[k] != 0) ? 0 : 1;
              mlap[k] = 1;
            end
            mpos[k] = (mpos[k] + ((mdir[k] != 0) ? 1 : n - 1)) % n;
          end
        end
        if (!mode) mdir[k] = up ? 1 : 0;
      end
    end
    if (rst) mvalid = 1'b1;
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (mvalid) begin
      chk("pos4", pos0, mpos[0]);
      chk("lap4", lap0, mlap[0]);
      chk("an4", an0, man[0]);
      chk("sseg4", sseg0, msseg[0]);
      chk("pos3", pos1, mpos[1]);
      chk("lap3", lap1, mlap[1]);
      chk("an3", an1, man[1]);
      chk("sseg3", sseg1, msseg[1]);
    end
  end

  task automatic wait_step(output int cycles);
    logic [2:0] prev;
    prev   = pos0;
    cycles = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      cycles++;
      if (pos0 !== prev) return;
    end
    chk("step_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_pos(input logic [2:0] target);
    for (int n = 0; n < 200; n++) begin
      if (pos0 === target) return;
      @(negedge clk);
    end
    chk("wait_pos_timeout", pos0, target);
  endtask

  task automatic scan_watch(input logic [3:0] an_exp, input logic [6:0] pat, input string nm);
    int seen;
    seen = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (an0 === an_exp) begin
        seen++;
        chk({nm, "_lit"}, sseg0, pat);
      end else begin
        chk({nm, "_blank"}, sseg0, 7'h7F);
      end
    end
    chk({nm, "_slots"}, seen, 4);
  endtask

  initial begin
    int lapcnt0, lapcnt1, lappos0, cyc;
    rst = 1'b1; en = 1'b0; up = 1'b1; mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_an", an0, 4'hF);
    chk("rst_sseg", sseg0, 7'h7F);
    chk("rst_pos", pos0, 3'd0);
    chk("rst_lap", lap0, 1'b0);

    // Rotate clockwise for 36 cycles: nine steps, one lap at 7->0.
    rst = 1'b0; en = 1'b1;
    lapcnt0 = 0; lapcnt1 = 0; lappos0 = -1;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("first_an", an0, 4'b1110);
        chk("first_sseg", sseg0, 7'h7F);
      end
      if (i == 3) chk("pos_before_step", pos0, 3'd0);
      if (i == 4) chk("first_step", pos0, 3'd1);
      if (lap0) begin lapcnt0++; lappos0 = pos0; end
      if (lap1) lapcnt1++;
    end
    chk("lap_count4", lapcnt0, 1);
    chk("lap_pos4", lappos0, 0);
    chk("pos_after36", pos0, 3'd1);
    chk("pos3_after36", pos1, 3'd3);
    chk("lap_count3", lapcnt1, 1);

    // Freeze mid-interval; the residual two counts must remain afterwards.
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (20) @(negedge clk);
    chk("frozen_pos", pos0, 3'd1);
    en = 1'b1;
    wait_step(cyc);
    chk("residual_cycles", cyc, 2);
    chk("resume_pos", pos0, 3'd2);

    // Counter-clockwise through the wrap.
    up = 1'b0;
    wait_step(cyc); chk("ccw_1", pos0, 3'd1);
    wait_step(cyc); chk("ccw_0", pos0, 3'd0);
    wait_step(cyc); chk("ccw_7", pos0, 3'd7); chk("ccw_lap", lap0, 1'b1);
    wait_step(cyc); chk("ccw_6", pos0, 3'd6); chk("ccw_nolap", lap0, 1'b0);

    // Bounce from pos 6 heading up.
    up = 1'b1;
    @(negedge clk);
    mode = 1'b1;
    up   = 1'b0;
    wait_step(cyc); chk("bnc_7", pos0, 3'd7); chk("bnc_7_lap", lap0, 1'b0);
    wait_step(cyc); chk("bnc_6", pos0, 3'd6); chk("bnc_top_lap", lap0, 1'b1);
    for (int s = 0; s < 6; s++) wait_step(cyc);
    chk("bnc_0", pos0, 3'd0);
    wait_step(cyc); chk("bnc_1", pos0, 3'd1); chk("bnc_bot_lap", lap0, 1'b1);

    // Display decode for a lower and an upper square.
    mode = 1'b0; up = 1'b1;
    wait_pos(3'd5);
    en = 1'b0;
    repeat (2) @(negedge clk);
    scan_watch(4'b1101, 7'h23, "pos5");
    en = 1'b1;
    wait_pos(3'd0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    scan_watch(4'b0111, 7'h1C, "pos0");

    // Reset in the middle of a step interval.
    en = 1'b1; mode = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", an0, 4'hF);
    chk("midrst_sseg", sseg0, 7'h7F);
    chk("midrst_pos", pos0, 3'd0);
    rst = 1'b0;

    // Random phase.
    for (int n = 0; n < 3000; n++) begin
      en  = ($urandom_range(0, 9) != 0);
      up  = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
